// File: rtl/bank_cmd_issuer.sv
// Single-bank DRAM command issuer: ACT/RD/WR/PR/REF sequencing, open-row tracking, periodic
// refresh and read-data window. Define AUTO_PRECHARGE_EN for closed-page (auto-precharge) mode.
module bank_cmd_issuer #(
  parameter int T_CL   = 17,
  parameter int T_RCD  = 17,
  parameter int T_RP   = 17,
  parameter int T_RFC  = 34,
  parameter int T_REFI = 3900,
  parameter int BL     = 8,
  parameter int ROW_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [ROW_W-1:0] req_row,
  output logic             cmd_act,
  output logic             cmd_rd,
  output logic             cmd_wr,
  output logic             cmd_pr,
  output logic             cmd_ref,
  output logic             cmd_ap,
  output logic [ROW_W-1:0] cmd_row,
  output logic             rd_window,
  output logic             open_row_valid,
  output logic             busy
);

  if (T_CL < 1 || T_CL > 255 || T_RCD < 1 || T_RCD > 255 || T_RP < 1 || T_RP > 255 ||
      T_RFC < 1 || T_RFC > 255 || T_REFI < 2 || T_REFI > 65535 || BL < 1 || BL > 255 ||
      ROW_W < 1) begin : g_bad_param
    $error("bank_cmd_issuer: parameter out of legal range");
  end

`ifdef AUTO_PRECHARGE_EN
  localparam bit AP = 1'b1;
`else
  localparam bit AP = 1'b0;
`endif

  localparam logic [7:0]  RCD_LD  = 8'(T_RCD - 1);
  localparam logic [7:0]  RP_LD   = 8'(T_RP - 1);
  localparam logic [7:0]  RFC_LD  = 8'(T_RFC - 1);
  localparam logic [7:0]  BL_LD   = 8'(BL - 1);
  localparam logic [15:0] REFI_LD = 16'(T_REFI - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT_WAIT, S_ACTIVE, S_BURST, S_PRE_WAIT, S_REF_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         wait_q, wait_d;
  logic [15:0]        refi_q;
  logic               ref_pend_q;
  logic               cmd_act_q, cmd_act_d, cmd_rd_q, cmd_rd_d, cmd_wr_q, cmd_wr_d;
  logic               cmd_pr_q, cmd_pr_d, cmd_ref_q, cmd_ref_d, cmd_ap_q, cmd_ap_d;
  logic [ROW_W-1:0]   cmd_row_q, cmd_row_d, pend_row_q, pend_row_d;
  logic               pend_wr_q, pend_wr_d, pend_q, pend_d;
  logic               orv_q, orv_d;
  logic [T_CL-1:0]    rd_dly_q;
  logic               win_q;
  logic [7:0]         win_cnt_q;

  logic ref_req, col_open, accept, active_step, col_issue, col_wr, ref_clr;

  // A counter expiry blocks new work in the same cycle it is seen, not one cycle later.
  assign ref_req  = ref_pend_q | (refi_q == '0);
  // The last burst cycle already satisfies column spacing, so it doubles as an ACTIVE decision point.
  assign col_open = !AP && ((state_q == S_ACTIVE) || (state_q == S_BURST && wait_q == '0));
  assign req_ready = !ref_req && ((state_q == S_IDLE) || col_open);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    cmd_act_d   = 1'b0;
    cmd_rd_d    = 1'b0;
    cmd_wr_d    = 1'b0;
    cmd_pr_d    = 1'b0;
    cmd_ref_d   = 1'b0;
    cmd_ap_d    = 1'b0;
    cmd_row_d   = cmd_row_q;
    pend_row_d  = pend_row_q;
    pend_wr_d   = pend_wr_q;
    pend_d      = pend_q;
    orv_d       = orv_q | cmd_act_q;
    active_step = 1'b0;
    col_issue   = 1'b0;
    col_wr      = 1'b0;
    ref_clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ref_req) begin
          cmd_ref_d = 1'b1;
          state_d   = S_REF_WAIT;
          wait_d    = RFC_LD;
        end else if (accept) begin
          cmd_act_d = 1'b1;
          cmd_row_d = req_row;
          pend_wr_d = req_write;
          state_d   = S_ACT_WAIT;
          wait_d    = RCD_LD;
        end
      end
      S_ACT_WAIT: begin
        if (wait_q == '0) begin
          col_issue = 1'b1;
          col_wr    = pend_wr_q;
        end else wait_d = wait_q - 8'd1;
      end
      S_BURST: begin
        if (wait_q != '0) wait_d = wait_q - 8'd1;
        else if (AP) begin
          state_d = S_PRE_WAIT;
          wait_d  = RP_LD;
          orv_d   = 1'b0;
        end else active_step = 1'b1;
      end
      S_ACTIVE: active_step = 1'b1;
      S_PRE_WAIT: begin
        if (wait_q != '0) wait_d = wait_q - 8'd1;
        else if (pend_q) begin
          cmd_act_d = 1'b1;
          cmd_row_d = pend_row_q;
          pend_d    = 1'b0;
          state_d   = S_ACT_WAIT;
          wait_d    = RCD_LD;
        end else if (AP) state_d = S_IDLE;
        else begin
          cmd_ref_d = 1'b1;
          state_d   = S_REF_WAIT;
          wait_d    = RFC_LD;
        end
      end
      S_REF_WAIT: begin
        if (wait_q != '0) wait_d = wait_q - 8'd1;
        else begin
          state_d = S_IDLE;
          ref_clr = 1'b1;
          orv_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (active_step) begin
      state_d = S_ACTIVE;
      if (ref_req) begin
        cmd_pr_d = 1'b1;
        orv_d    = 1'b0;
        pend_d   = 1'b0;
        state_d  = S_PRE_WAIT;
        wait_d   = RP_LD;
      end else if (accept) begin
        if (req_row == cmd_row_q) begin
          col_issue = 1'b1;
          col_wr    = req_write;
        end else begin
          cmd_pr_d   = 1'b1;
          orv_d      = 1'b0;
          pend_d     = 1'b1;
          pend_row_d = req_row;
          pend_wr_d  = req_write;
          state_d    = S_PRE_WAIT;
          wait_d     = RP_LD;
        end
      end
    end

    if (col_issue) begin
      cmd_rd_d = !col_wr;
      cmd_wr_d = col_wr;
      cmd_ap_d = AP;
      state_d  = S_BURST;
      wait_d   = BL_LD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      refi_q     <= REFI_LD;
      ref_pend_q <= 1'b0;
      cmd_act_q  <= 1'b0;
      cmd_rd_q   <= 1'b0;
      cmd_wr_q   <= 1'b0;
      cmd_pr_q   <= 1'b0;
      cmd_ref_q  <= 1'b0;
      cmd_ap_q   <= 1'b0;
      cmd_row_q  <= '0;
      pend_row_q <= '0;
      pend_wr_q  <= 1'b0;
      pend_q     <= 1'b0;
      orv_q      <= 1'b0;
      rd_dly_q   <= '0;
      win_q      <= 1'b0;
      win_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      refi_q     <= (refi_q == '0) ? REFI_LD : refi_q - 16'd1;
      ref_pend_q <= (refi_q == '0) | (ref_pend_q & ~ref_clr);
      cmd_act_q  <= cmd_act_d;
      cmd_rd_q   <= cmd_rd_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_pr_q   <= cmd_pr_d;
      cmd_ref_q  <= cmd_ref_d;
      cmd_ap_q   <= cmd_ap_d;
      cmd_row_q  <= cmd_row_d;
      pend_row_q <= pend_row_d;
      pend_wr_q  <= pend_wr_d;
      pend_q     <= pend_d;
      orv_q      <= orv_d;
      // RD pulse delayed by T_CL; each arrival (re)starts a BL-long window so overlaps merge.
      rd_dly_q   <= (rd_dly_q << 1) | T_CL'(cmd_rd_d);
      if (rd_dly_q[T_CL-1]) begin
        win_q     <= 1'b1;
        win_cnt_q <= BL_LD;
      end else if (win_cnt_q != '0) win_cnt_q <= win_cnt_q - 8'd1;
      else win_q <= 1'b0;
    end
  end

  assign cmd_act        = cmd_act_q;
  assign cmd_rd         = cmd_rd_q;
  assign cmd_wr         = cmd_wr_q;
  assign cmd_pr         = cmd_pr_q;
  assign cmd_ref        = cmd_ref_q;
  assign cmd_ap         = cmd_ap_q;
  assign cmd_row        = cmd_row_q;
  assign rd_window      = win_q;
  assign open_row_valid = orv_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_ACTIVE);

endmodule

// File: tb/tb_bank_cmd_issuer.sv
// Bench for bank_cmd_issuer: vector table over several scenarios plus a back-to-back read sequence.
// Cycle c is the clock period ending at edge c; edge 0 is the first edge with rst low.
module tb_bank_cmd_issuer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_v = 2'b11, vld_v = 2'b00, wr_v = 2'b00;
  logic [15:0] row_v [2];
  logic [25:0] got [2];   // {ap,ref,pr,wr,rd,act, cmd_row, win, orv, rdy, busy}

  // Instance 0 uses default timing, instance 1 a short refresh interval.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic rdy, act, rd, wr, pr, rf, ap, win, orv, bsy;
    logic [15:0] crow;
    bank_cmd_issuer #(.T_REFI(g == 0 ? 3900 : 100)) u_dut (
      .clk(clk), .rst(rst_v[g]), .req_valid(vld_v[g]), .req_ready(rdy),
      .req_write(wr_v[g]), .req_row(row_v[g]),
      .cmd_act(act), .cmd_rd(rd), .cmd_wr(wr), .cmd_pr(pr), .cmd_ref(rf), .cmd_ap(ap),
      .cmd_row(crow), .rd_window(win), .open_row_valid(orv), .busy(bsy));
    assign got[g] = {ap, rf, pr, wr, rd, act, crow, win, orv, rdy, bsy};
  end

  localparam logic [5:0] ACT = 6'h01, RD = 6'h02, WR = 6'h04, PR = 6'h08, RF = 6'h10;

  typedef struct {
    int sc; int cyc;
    logic rst, vld, wr; logic [15:0] row;
    logic [5:0] cmd; logic [15:0] crow; logic win, orv, rdy, bsy;
  } vec_t;
  vec_t vt[$];

  int n_run = 0, n_fail = 0;

  task automatic add(input int sc, input int cyc, input logic rst, input logic vld, input logic wr,
                     input logic [15:0] row, input logic [5:0] cmd, input logic [15:0] crow,
                     input logic win, input logic orv, input logic rdy, input logic bsy);
    vec_t r;
    r.sc = sc; r.cyc = cyc; r.rst = rst; r.vld = vld; r.wr = wr; r.row = row;
    r.cmd = cmd; r.crow = crow; r.win = win; r.orv = orv; r.rdy = rdy; r.bsy = bsy;
    vt.push_back(r);
  endtask

  function automatic string fmt(input logic [25:0] x);
    return $sformatf("cmd=%b row=%h win=%b orv=%b rdy=%b busy=%b",
                     x[25:20], x[19:4], x[3], x[2], x[1], x[0]);
  endfunction

  task automatic start(input int sel);
    rst_v = 2'b11; vld_v = 2'b00; wr_v = 2'b00; row_v[0] = '0; row_v[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst_v[sel] = 1'b0;
  endtask

  // Inputs in a record are held from its cycle until the next record; off-record cycles must be command-free.
  task automatic run_sc(input int sc, input int sel, input int last);
    vec_t cur;
    bit found;
    logic [25:0] exp;
    start(sel);
    for (int c = 0; c <= last; c++) begin
      found = 1'b0;
      foreach (vt[i]) if (vt[i].sc == sc && vt[i].cyc == c) begin found = 1'b1; cur = vt[i]; end
      if (found) begin
        rst_v[sel] = cur.rst; vld_v[sel] = cur.vld; wr_v[sel] = cur.wr; row_v[sel] = cur.row;
      end
      #1;
      n_run++;
      if (found) begin
        exp = {cur.cmd, cur.crow, cur.win, cur.orv, cur.rdy, cur.bsy};
        if (got[sel] !== exp) begin
          n_fail++;
          $display("FAIL sc%0d cyc%0d outputs: got %s, want %s", sc, c, fmt(got[sel]), fmt(exp));
        end
      end else if (got[sel][25:20] !== 6'b0) begin
        n_fail++;
        $display("FAIL sc%0d cyc%0d stray command: got %b, want 000000", sc, c, got[sel][25:20]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Two same-row reads 8 cycles apart: their data windows must merge into one 16-cycle window.
  task automatic seq_b2b_reads();
    bit acc2 = 1'b0;
    int acc_cyc = -1;
    logic exp_w;
    start(0);
    for (int c = 0; c <= 52; c++) begin
      row_v[0] = 16'h0012; wr_v[0] = 1'b0;
      vld_v[0] = (c == 0) || (c >= 2 && !acc2);
      #1;
      if (c >= 2 && vld_v[0] && got[0][1]) begin acc2 = 1'b1; acc_cyc = c; end
      if (c >= 34 && c <= 51) begin
        exp_w = (c >= 35 && c <= 50);
        n_run++;
        if (got[0][3] !== exp_w) begin
          n_fail++;
          $display("FAIL b2b cyc%0d rd_window: got %b, want %b", c, got[0][3], exp_w);
        end
      end
      if (c == 26) begin
        n_run++;
        if (got[0][25:20] !== RD) begin
          n_fail++;
          $display("FAIL b2b cyc26 second cmd_rd: got %b, want %b", got[0][25:20], RD);
        end
      end
      @(posedge clk);
      #1;
    end
    n_run++;
    if (acc_cyc != 25) begin
      n_fail++;
      $display("FAIL b2b accept cycle: got %0d, want 25", acc_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // sc0: read from IDLE, then row-hit write
    add(0,  0, 0,1,0,16'h0012, 0,  16'h0000, 0,0,1,0);
    add(0,  1, 0,0,0,16'h0000, ACT,16'h0012, 0,0,0,1);
    add(0,  2, 0,0,0,16'h0000, 0,  16'h0012, 0,1,0,1);
    add(0, 18, 0,0,0,16'h0000, RD, 16'h0012, 0,1,0,1);
    add(0, 19, 0,1,1,16'h0012, 0,  16'h0012, 0,1,0,1);
    add(0, 24, 0,1,1,16'h0012, 0,  16'h0012, 0,1,0,1);
    add(0, 25, 0,1,1,16'h0012, 0,  16'h0012, 0,1,1,1);
    add(0, 26, 0,0,0,16'h0000, WR, 16'h0012, 0,1,0,1);
    add(0, 33, 0,0,0,16'h0000, 0,  16'h0012, 0,1,1,1);
    add(0, 34, 0,0,0,16'h0000, 0,  16'h0012, 0,1,1,0);
    add(0, 35, 0,0,0,16'h0000, 0,  16'h0012, 1,1,1,0);
    add(0, 42, 0,0,0,16'h0000, 0,  16'h0012, 1,1,1,0);
    add(0, 43, 0,0,0,16'h0000, 0,  16'h0012, 0,1,1,0);
    // sc1: row miss
    add(1,  0, 0,1,0,16'h0012, 0,  16'h0000, 0,0,1,0);
    add(1,  1, 0,0,0,16'h0000, ACT,16'h0012, 0,0,0,1);
    add(1, 18, 0,0,0,16'h0000, RD, 16'h0012, 0,1,0,1);
    add(1, 19, 0,1,0,16'h0034, 0,  16'h0012, 0,1,0,1);
    add(1, 25, 0,1,0,16'h0034, 0,  16'h0012, 0,1,1,1);
    add(1, 26, 0,0,0,16'h0000, PR, 16'h0012, 0,0,0,1);
    add(1, 35, 0,0,0,16'h0000, 0,  16'h0012, 1,0,0,1);
    add(1, 42, 0,0,0,16'h0000, 0,  16'h0012, 1,0,0,1);
    add(1, 43, 0,0,0,16'h0000, ACT,16'h0034, 0,0,0,1);
    add(1, 44, 0,0,0,16'h0000, 0,  16'h0034, 0,1,0,1);
    add(1, 60, 0,0,0,16'h0000, RD, 16'h0034, 0,1,0,1);
    add(1, 68, 0,0,0,16'h0000, 0,  16'h0034, 0,1,1,0);
    add(1, 77, 0,0,0,16'h0000, 0,  16'h0034, 1,1,1,0);
    add(1, 84, 0,0,0,16'h0000, 0,  16'h0034, 1,1,1,0);
    add(1, 85, 0,0,0,16'h0000, 0,  16'h0034, 0,1,1,0);
    // sc2: refresh from idle, T_REFI=100
    add(2,  0, 0,0,0,16'h0000, 0,  16'h0000, 0,0,1,0);
    add(2, 98, 0,0,0,16'h0000, 0,  16'h0000, 0,0,1,0);
    add(2, 99, 0,0,0,16'h0000, 0,  16'h0000, 0,0,0,0);
    add(2,100, 0,0,0,16'h0000, RF, 16'h0000, 0,0,0,1);
    add(2,120, 0,1,1,16'h0055, 0,  16'h0000, 0,0,0,1);
    add(2,133, 0,1,1,16'h0055, 0,  16'h0000, 0,0,0,1);
    add(2,134, 0,1,1,16'h0055, 0,  16'h0000, 0,0,1,0);
    add(2,135, 0,0,0,16'h0000, ACT,16'h0055, 0,0,0,1);
    // sc3: refresh with a row open, T_REFI=100
    add(3,  0, 0,1,0,16'h0012, 0,  16'h0000, 0,0,1,0);
    add(3,  1, 0,0,0,16'h0000, ACT,16'h0012, 0,0,0,1);
    add(3, 18, 0,0,0,16'h0000, RD, 16'h0012, 0,1,0,1);
    add(3, 26, 0,0,0,16'h0000, 0,  16'h0012, 0,1,1,0);
    add(3, 35, 0,0,0,16'h0000, 0,  16'h0012, 1,1,1,0);
    add(3, 42, 0,0,0,16'h0000, 0,  16'h0012, 1,1,1,0);
    add(3, 43, 0,0,0,16'h0000, 0,  16'h0012, 0,1,1,0);
    add(3, 99, 0,0,0,16'h0000, 0,  16'h0012, 0,1,0,0);
    add(3,100, 0,0,0,16'h0000, PR, 16'h0012, 0,0,0,1);
    add(3,117, 0,0,0,16'h0000, RF, 16'h0012, 0,0,0,1);
    add(3,150, 0,0,0,16'h0000, 0,  16'h0012, 0,0,0,1);
    add(3,151, 0,0,0,16'h0000, 0,  16'h0012, 0,0,1,0);
    // sc4: reset during ACT_WAIT
    add(4,  0, 0,1,0,16'h0012, 0,  16'h0000, 0,0,1,0);
    add(4,  1, 0,0,0,16'h0000, ACT,16'h0012, 0,0,0,1);
    add(4, 10, 1,0,0,16'h0000, 0,  16'h0012, 0,1,0,1);
    add(4, 11, 0,0,0,16'h0000, 0,  16'h0000, 0,0,1,0);
    add(4, 30, 0,0,0,16'h0000, 0,  16'h0000, 0,0,1,0);

    run_sc(0, 0, 45);
    run_sc(1, 0, 90);
    run_sc(2, 1, 140);
    run_sc(3, 1, 155);
    run_sc(4, 0, 45);
    seq_b2b_reads();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
